// File: rtl/ecg_stim_pkg.sv
// Shared constants, phase encoding and saturation helper
// for the synthetic ECG stimulus source.
package ecg_stim_pkg;

    localparam int P_START    = 0;
    localparam int P_LEN      = 16;
    localparam int PR_START   = 16;
    localparam int PR_LEN     = 8;
    localparam int QRS_START  = 24;
    localparam int QRS_LEN    = 16;
    localparam int ST_START   = 40;
    localparam int ST_LEN     = 16;
    localparam int T_START    = 56;
    localparam int T_LEN      = 32;
    localparam int IDLE_START = 88;
    localparam int MIN_BEAT   = 96;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_P    = 3'd1,
        PH_PR   = 3'd2,
        PH_QRS  = 3'd3,
        PH_ST   = 3'd4,
        PH_T    = 3'd5
    } phase_t;

    function automatic logic signed [15:0] sat16(
        input logic signed [16:0] v
    );
        if (v > 17'sd32767)
            return 16'sh7FFF;
        else if (v < -17'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/ecg_stim_source_template.sv
// Combinational P-QRS-T beat template: maps the sample index
// and latched R amplitude to a template value and segment.
module ecg_beat_template
    import ecg_stim_pkg::*;
#(
    parameter int BEAT_W = 12
) (
    input  logic [BEAT_W-1:0] sidx,
    input  logic [15:0]       qrs_amp_q,
    output logic [15:0]       value,
    output logic [2:0]        phase
);

    phase_t             ph;
    logic [4:0]         k;
    logic [4:0]         tri_v;
    logic [2:0]         sh;
    logic signed [15:0] amp_s;
    logic signed [15:0] base;
    logic signed [20:0] base_x;
    logic signed [20:0] tri_x;
    logic signed [20:0] prod;
    logic signed [20:0] shifted;

    assign amp_s = qrs_amp_q;

    always_comb begin
        ph   = PH_IDLE;
        k    = '0;
        base = '0;
        sh   = 3'd3;
        if (sidx < BEAT_W'(PR_START)) begin
            ph   = PH_P;
            k    = 5'(sidx);
            base = amp_s >>> 3;
        end else if (sidx < BEAT_W'(QRS_START)) begin
            ph = PH_PR;
        end else if (sidx < BEAT_W'(ST_START)) begin
            ph   = PH_QRS;
            k    = 5'(sidx - BEAT_W'(QRS_START));
            base = amp_s;
        end else if (sidx < BEAT_W'(T_START)) begin
            ph = PH_ST;
        end else if (sidx < BEAT_W'(IDLE_START)) begin
            ph   = PH_T;
            k    = 5'(sidx - BEAT_W'(T_START));
            base = amp_s >>> 2;
            sh   = 3'd4;
        end
        // T uses a 32-sample triangle, P and QRS a 16-sample one
        if (ph == PH_T)
            tri_v = (k < 5'd16) ? k : 5'(6'd32 - {1'b0, k});
        else
            tri_v = (k < 5'd8) ? k : 5'(5'd16 - k);
        base_x  = 21'(base);
        tri_x   = 21'(tri_v);
        prod    = base_x * tri_x;
        shifted = prod >>> sh;
    end

    assign value = shifted[15:0];
    assign phase = ph;

endmodule

// File: rtl/ecg_stim_source.sv
// Synthetic ECG sample source: rate divider, beat index,
// bounded triangular drift and registered sample output.
module ecg_stim_source
    import ecg_stim_pkg::*;
#(
    parameter int RATE_W = 16,
    parameter int BEAT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [RATE_W-1:0] rate_div,
    input  logic [BEAT_W-1:0] beat_len,
    input  logic [15:0]       qrs_amp,
    input  logic [7:0]        drift_step,
    input  logic [14:0]       drift_lim,
    output logic              valid,
    output logic [15:0]       x_out,
    output logic              beat_start,
    output logic [2:0]        phase
);

    logic [RATE_W-1:0] tick_cnt;
    logic [RATE_W-1:0] rate_q;
    logic [BEAT_W-1:0] len_q;
    logic [15:0]       amp_q;
    logic [7:0]        step_q;
    logic [14:0]       lim_q;
    logic [BEAT_W-1:0] sidx;
    logic signed [15:0] drift;
    logic              dir;

    logic              load;
    logic              tick;
    logic [BEAT_W-1:0] len_clamp;
    logic [RATE_W-1:0] rate_eff;
    logic [BEAT_W-1:0] len_eff;
    logic [7:0]        step_eff;
    logic [14:0]       lim_eff;

    logic signed [16:0] d_ext;
    logic signed [16:0] s_ext;
    logic signed [16:0] l_ext;
    logic signed [16:0] neg_lim;
    logic signed [16:0] sum;
    logic signed [15:0] drift_nx;
    logic               dir_nx;

    logic signed [15:0] tpl_val;
    logic [2:0]         tpl_ph;
    logic signed [16:0] out_sum;

    // New beat parameters take effect on the first edge of a beat
    assign load      = en && (tick_cnt == '0) && (sidx == '0);
    assign len_clamp = (beat_len < BEAT_W'(MIN_BEAT)) ?
                       BEAT_W'(MIN_BEAT) : beat_len;
    assign rate_eff  = load ? rate_div   : rate_q;
    assign len_eff   = load ? len_clamp  : len_q;
    assign step_eff  = load ? drift_step : step_q;
    assign lim_eff   = load ? drift_lim  : lim_q;
    assign tick      = en && (tick_cnt == rate_eff);

    always_comb begin
        d_ext   = 17'(drift);
        s_ext   = {9'b0, step_eff};
        l_ext   = {2'b0, lim_eff};
        neg_lim = -l_ext;
        sum     = dir ? (d_ext + s_ext) : (d_ext - s_ext);
        dir_nx  = dir;
        drift_nx = sum[15:0];
        if (sum >= l_ext) begin
            drift_nx = l_ext[15:0];
            dir_nx   = 1'b0;
        end else if (sum <= neg_lim) begin
            drift_nx = neg_lim[15:0];
            dir_nx   = 1'b1;
        end
    end

    ecg_beat_template #(
        .BEAT_W(BEAT_W)
    ) u_tpl (
        .sidx      (sidx),
        .qrs_amp_q (amp_q),
        .value     (tpl_val),
        .phase     (tpl_ph)
    );

    assign out_sum = 17'(tpl_val) + d_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt   <= '0;
            rate_q     <= '0;
            len_q      <= '0;
            amp_q      <= '0;
            step_q     <= '0;
            lim_q      <= '0;
            sidx       <= '0;
            drift      <= '0;
            dir        <= 1'b1;
            valid      <= 1'b0;
            x_out      <= '0;
            beat_start <= 1'b0;
            phase      <= '0;
        end else begin
            valid      <= tick;
            beat_start <= tick && (sidx == '0);
            if (load) begin
                rate_q <= rate_div;
                len_q  <= len_clamp;
                amp_q  <= qrs_amp;
                step_q <= drift_step;
                lim_q  <= drift_lim;
            end
            if (en)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                x_out <= sat16(out_sum);
                phase <= tpl_ph;
                sidx  <= (sidx == len_eff - 1'b1) ? '0 : sidx + 1'b1;
                drift <= drift_nx;
                dir   <= dir_nx;
            end
        end
    end

endmodule
